// File: rtl/ram_arbiter.sv
// ram_arbiter: sequences one shared single-port ram between fetch (IF) and
// load/store (DM), one access in flight, with registered ram command and data.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             fetch request (level) and address
//   if_ready/instr_out         fetch done pulse and registered fetched word
//   pc_enable                  advance PC; identical to if_ready
//   dm_read/dm_write/dm_addr   data request (level), address
//   dm_wdata/dm_rdata          write data in, registered read data out
//   dm_ready                   data access done pulse
//   ram_addr/ram_ren/ram_wen   registered ram command
//   ram_wdata/ram_rdata        registered ram write data, ram read data
//   stall_cnt                  only with RAM_ARB_STALL_CNT_EN: saturating
//                              count of cycles with if_req high, if_ready low
//
// Optional macro: RAM_ARB_STALL_CNT_EN

module ram_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic              pc_enable,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [DATA_W-1:0] ram_wdata,
`ifdef RAM_ARB_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    // Extra WAIT_RD cycles after the first one.
    localparam logic [1:0]    WAIT_INIT  = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_RD,
        WAIT_RD,
        ISSUE_WR,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [1:0]        lat_q, lat_d;
    logic              own_dm_q, own_dm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              if_rdy_q, if_rdy_d;
    logic              dm_rdy_q, dm_rdy_d;
    logic              if_vld, dm_vld, if_force, cap;

    // A port in its ready cycle is masked so a still-high level request
    // cannot be issued twice.
    assign if_vld   = if_req & ~if_rdy_q;
    assign dm_vld   = (dm_read | dm_write) & ~dm_rdy_q;
    assign if_force = if_vld & (starve_q == STARVE_TOP);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        lat_d    = lat_q;
        own_dm_d = own_dm_q;
        addr_d   = addr_q;
        ren_d    = 1'b0;
        wen_d    = 1'b0;
        wdata_d  = wdata_q;
        instr_d  = instr_q;
        rdata_d  = rdata_q;
        if_rdy_d = 1'b0;
        dm_rdy_d = 1'b0;
        cap      = 1'b0;

        if (!if_req) starve_d = '0;

        case (state_q)
            IDLE: begin
                if (dm_vld && !if_force) begin
                    own_dm_d = 1'b1;
                    addr_d   = dm_addr;
                    // write wins when both read and write are requested
                    if (dm_write) begin
                        wen_d   = 1'b1;
                        wdata_d = dm_wdata;
                        state_d = ISSUE_WR;
                    end else begin
                        ren_d   = 1'b1;
                        state_d = ISSUE_RD;
                    end
                    if (if_req && starve_q != STARVE_TOP)
                        starve_d = starve_q + 1'b1;
                end else if (if_vld) begin
                    own_dm_d = 1'b0;
                    addr_d   = if_addr;
                    ren_d    = 1'b1;
                    starve_d = '0;
                    state_d  = ISSUE_RD;
                end
            end
            ISSUE_RD: begin
                // with LAT=1 the data is already valid in the strobe cycle
                if (LAT == 1) begin
                    cap     = 1'b1;
                    state_d = DONE;
                end else begin
                    lat_d   = WAIT_INIT;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (lat_q == 2'd0) begin
                    cap     = 1'b1;
                    state_d = DONE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ISSUE_WR: begin
                dm_rdy_d = 1'b1;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cap) begin
            if (own_dm_q) begin
                rdata_d  = ram_rdata;
                dm_rdy_d = 1'b1;
            end else begin
                instr_d  = ram_rdata;
                if_rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            lat_q    <= '0;
            own_dm_q <= 1'b0;
            addr_q   <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            instr_q  <= '0;
            rdata_q  <= '0;
            if_rdy_q <= 1'b0;
            dm_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lat_q    <= lat_d;
            own_dm_q <= own_dm_d;
            addr_q   <= addr_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            instr_q  <= instr_d;
            rdata_q  <= rdata_d;
            if_rdy_q <= if_rdy_d;
            dm_rdy_q <= dm_rdy_d;
        end
    end

`ifdef RAM_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (if_req && !if_rdy_q && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif

    assign if_ready  = if_rdy_q;
    assign pc_enable = if_rdy_q;
    assign instr_out = instr_q;
    assign dm_rdata  = rdata_q;
    assign dm_ready  = dm_rdy_q;
    assign ram_addr  = addr_q;
    assign ram_ren   = ren_q;
    assign ram_wen   = wen_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter at LAT=1,2,3
// sharing one stimulus; each instance has its own latency-accurate ram model.

module tb_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [4:0]  if_addr = '0;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [4:0]  dm_addr = '0;
    logic [31:0] dm_wdata = '0;

    logic        if_ready [3];
    logic [31:0] instr    [3];
    logic        pc_en    [3];
    logic [31:0] dm_rdata [3];
    logic        dm_ready [3];
    logic [4:0]  raddr    [3];
    logic        ren      [3];
    logic        wen      [3];
    logic [31:0] wdata    [3];
    logic [31:0] rdata    [3];
`ifdef RAM_ARB_STALL_CNT_EN
    logic [15:0] stall    [3];
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem [32];
        logic        v1 = 1'b0, v2 = 1'b0;
        logic [4:0]  a1 = '0, a2 = '0;
        logic        rv;
        logic [4:0]  ra;
        int          ifr_n = 0, dmr_n = 0, ren_n = 0, wen_n = 0;

        ram_arbiter #(.LAT(g + 1)) u (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_ready  (if_ready[g]),
            .instr_out (instr[g]),
            .pc_enable (pc_en[g]),
            .dm_read   (dm_read),
            .dm_write  (dm_write),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_rdata  (dm_rdata[g]),
            .dm_ready  (dm_ready[g]),
            .ram_addr  (raddr[g]),
            .ram_ren   (ren[g]),
            .ram_wen   (wen[g]),
            .ram_wdata (wdata[g]),
`ifdef RAM_ARB_STALL_CNT_EN
            .stall_cnt (stall[g]),
`endif
            .ram_rdata (rdata[g])
        );

        // data is driven only in cycle LAT after the strobe, junk otherwise
        assign rv = (g == 0) ? ren[g] : (g == 1) ? v1 : v2;
        assign ra = (g == 0) ? raddr[g] : (g == 1) ? a1 : a2;
        assign rdata[g] = rv ? mem[ra] : 32'hBAD0_BAD0;

        initial begin
            for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
            mem[3] = 32'hDEAD_BEEF;
            forever begin
                @(posedge clk);
                v1 <= ren[g];
                a1 <= raddr[g];
                v2 <= v1;
                a2 <= a1;
                if (wen[g]) mem[raddr[g]] <= wdata[g];
                ifr_n <= ifr_n + (if_ready[g] ? 1 : 0);
                dmr_n <= dmr_n + (dm_ready[g] ? 1 : 0);
                ren_n <= ren_n + (ren[g] ? 1 : 0);
                wen_n <= wen_n + (wen[g] ? 1 : 0);
            end
        end
    end

    bit rec_on = 1'b0;
    int grants [$];

    always @(posedge clk)
        if (rec_on && ren[0]) grants.push_back(raddr[0] == 5'd3 ? 1 : 0);

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int n0, n2, w0, r0, d0, p0, k, cyc;

    initial begin
        rst = 1'b1;
        tick(2);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_instr%0d", g), instr[g], 32'd0);
            chk($sformatf("rst_dmrd%0d", g), dm_rdata[g], 32'd0);
            chk($sformatf("rst_flags%0d", g),
                32'({if_ready[g], pc_en[g], dm_ready[g], ren[g], wen[g]}),
                32'd0);
            chk($sformatf("rst_addr%0d", g), 32'(raddr[g]), 32'd0);
            chk($sformatf("rst_wdata%0d", g), wdata[g], 32'd0);
        end
        rst = 1'b0;
        tick(1);

        // fetch of word 3
        n0 = g_dut[0].ifr_n;
        n2 = g_dut[2].ifr_n;
        if_req = 1'b1;
        if_addr = 5'd3;
        tick(1);
        chk("t1_ren", 32'(ren[0]), 32'd1);
        chk("t1_addr", 32'(raddr[0]), 32'd3);
        chk("t1_rdy_c1", 32'(if_ready[0]), 32'd0);
        tick(1);
        chk("t1_rdy", 32'(if_ready[0]), 32'd1);
        chk("t1_pce", 32'(pc_en[0]), 32'd1);
        chk("t1_instr", instr[0], 32'hDEAD_BEEF);
        if_req = 1'b0;
        tick(8);
        chk("t1_pulses", 32'(g_dut[0].ifr_n - n0), 32'd1);
        chk("t1_drop_pulse", 32'(g_dut[2].ifr_n - n2), 32'd1);
        chk("t1_drop_instr", instr[2], 32'hDEAD_BEEF);

        // write then read back address 7
        w0 = g_dut[0].wen_n;
        r0 = g_dut[0].ren_n;
        d0 = g_dut[0].dmr_n;
        dm_write = 1'b1;
        dm_addr = 5'd7;
        dm_wdata = 32'h1234_5678;
        tick(1);
        chk("t2_wen", 32'(wen[0]), 32'd1);
        chk("t2_waddr", 32'(raddr[0]), 32'd7);
        chk("t2_wdata", wdata[0], 32'h1234_5678);
        tick(1);
        chk("t2_wrdy", 32'(dm_ready[0]), 32'd1);
        chk("t2_wen_off", 32'(wen[0]), 32'd0);
        dm_write = 1'b0;
        dm_read = 1'b1;
        tick(2);
        chk("t2_ren", 32'(ren[0]), 32'd1);
        tick(1);
        chk("t2_rrdy", 32'(dm_ready[0]), 32'd1);
        chk("t2_rdata", dm_rdata[0], 32'h1234_5678);
        dm_read = 1'b0;
        tick(8);
        chk("t2_nwen", 32'(g_dut[0].wen_n - w0), 32'd1);
        chk("t2_nren", 32'(g_dut[0].ren_n - r0), 32'd1);
        chk("t2_nrdy", 32'(g_dut[0].dmr_n - d0), 32'd2);

        // read and write together act as a write
        w0 = g_dut[0].wen_n;
        r0 = g_dut[0].ren_n;
        d0 = g_dut[0].dmr_n;
        dm_read = 1'b1;
        dm_write = 1'b1;
        dm_addr = 5'd9;
        dm_wdata = 32'hAAAA_5555;
        tick(1);
        chk("t3_wen", 32'(wen[0]), 32'd1);
        chk("t3_ren", 32'(ren[0]), 32'd0);
        tick(1);
        chk("t3_rdy", 32'(dm_ready[0]), 32'd1);
        dm_read = 1'b0;
        dm_write = 1'b0;
        tick(6);
        chk("t3_nwen", 32'(g_dut[0].wen_n - w0), 32'd1);
        chk("t3_nren", 32'(g_dut[0].ren_n - r0), 32'd0);
        chk("t3_nrdy", 32'(g_dut[0].dmr_n - d0), 32'd1);
        chk("t3_mem", g_dut[0].mem[9], 32'hAAAA_5555);

        // starvation: both requesters held high
        p0 = g_dut[0].ifr_n;
        grants.delete();
        rec_on = 1'b1;
        if_req = 1'b1;
        if_addr = 5'd3;
        dm_read = 1'b1;
        dm_addr = 5'd7;
        tick(32);
        rec_on = 1'b0;
        if_req = 1'b0;
        dm_read = 1'b0;
        tick(8);
        chk("t4_ngrants", 32'(grants.size()), 32'd11);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            chk($sformatf("t4_grant%0d", i), 32'(grants[i]),
                (i % 5 == 4) ? 32'd1 : 32'd0);
        chk("t4_pce", 32'(g_dut[0].ifr_n - p0), 32'd2);

        // reset while LAT=3 instance is in WAIT_RD
        n2 = g_dut[2].ifr_n;
        if_req = 1'b1;
        if_addr = 5'd3;
        tick(2);
        rst = 1'b1;
        if_req = 1'b0;
        tick(1);
        chk("t5_rdy", 32'(if_ready[2]), 32'd0);
        chk("t5_pce", 32'(pc_en[2]), 32'd0);
        chk("t5_instr", instr[2], 32'd0);
        chk("t5_ren", 32'(ren[2]), 32'd0);
        chk("t5_addr", 32'(raddr[2]), 32'd0);
        chk("t5_dmrd", dm_rdata[2], 32'd0);
        rst = 1'b0;
        tick(6);
        chk("t5_nopulse", 32'(g_dut[2].ifr_n - n2), 32'd0);
        if_req = 1'b1;
        if_addr = 5'd4;
        cyc = 0;
        while (cyc < 12) begin
            tick(1);
            cyc++;
            if (if_ready[2]) break;
        end
        chk("t5_lat", 32'(cyc), 32'd4);
        chk("t5_instr2", instr[2], 32'hA000_0004);
        chk("t5_pce2", 32'(pc_en[2]), 32'd1);
        if_req = 1'b0;
        tick(8);

`ifdef RAM_ARB_STALL_CNT_EN
        // 10 back-to-back fetches on the LAT=2 instance
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_rst", 32'(stall[1]), 32'd0);
        if_req = 1'b1;
        if_addr = 5'd0;
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 200) begin
            tick(1);
            cyc++;
            if (if_ready[1]) begin
                k++;
                if_addr = if_addr + 5'd1;
            end
        end
        if_req = 1'b0;
        chk("t6_fetches", 32'(k), 32'd10);
        chk("t6_stall", 32'(stall[1]), 32'd30);
        tick(2);
        chk("t6_hold", 32'(stall[1]), 32'd30);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
